// File: rtl/temp_display_scanner_pkg.sv
// temp_disp_pkg: shared constants, FSM states and helpers for the temperature display scanner
package temp_disp_pkg;
   localparam logic [19:0] SCALE_K     = 20'hBFB04;
   localparam logic [8:0]  TEMP_OFFSET = 9'd100;
   localparam logic [6:0]  SEG_BLANK   = 7'b1111111;
   localparam logic [6:0]  SEG_0       = 7'b1000000;
   localparam logic [6:0]  SEG_1       = 7'b1111001;
   localparam logic [6:0]  SEG_2       = 7'b0100100;
   localparam logic [6:0]  SEG_3       = 7'b0110000;
   localparam logic [6:0]  SEG_4       = 7'b0011001;
   localparam logic [6:0]  SEG_5       = 7'b0010010;
   localparam logic [6:0]  SEG_6       = 7'b0000010;
   localparam logic [6:0]  SEG_7       = 7'b1111000;
   localparam logic [6:0]  SEG_8       = 7'b0000000;
   localparam logic [6:0]  SEG_9       = 7'b0010000;

   typedef enum logic [1:0] {IDLE, CONV, LOAD} state_t;

   function automatic logic [8:0] scale_temp(input logic [7:0] d);
      return 9'((28'(d) * 28'(SCALE_K)) >> 20) + TEMP_OFFSET;
   endfunction

   function automatic logic [6:0] seg_enc(input logic [3:0] n);
      case (n)
         4'd0: return SEG_0;
         4'd1: return SEG_1;
         4'd2: return SEG_2;
         4'd3: return SEG_3;
         4'd4: return SEG_4;
         4'd5: return SEG_5;
         4'd6: return SEG_6;
         4'd7: return SEG_7;
         4'd8: return SEG_8;
         4'd9: return SEG_9;
         default: return SEG_BLANK;
      endcase
   endfunction

   // one double-dabble iteration on {bcd[11:0], bin[8:0]}
   function automatic logic [20:0] dd_step(input logic [20:0] s);
      logic [20:0] t;
      t = s;
      for (int i = 0; i < 3; i++)
         if (t[9 + 4*i +: 4] > 4'd4) t[9 + 4*i +: 4] = t[9 + 4*i +: 4] + 4'd3;
      return t << 1;
   endfunction
endpackage

// File: rtl/temp_display_scanner_if.sv
// temp_display_scanner_if: valid/ready sample handshake from the capture stage
interface temp_display_scanner_if;
   logic       sample_valid;
   logic [7:0] sample_data;
   logic       sample_ready;
   modport master (output sample_valid, sample_data, input sample_ready);
   modport slave (input sample_valid, sample_data, output sample_ready);
endinterface

// File: rtl/temp_display_scanner_bin2bcd.sv
// bin2bcd_seq: 9-bit binary to 3-digit BCD, one shift-and-add-3 step per cycle
module bin2bcd_seq
   import temp_disp_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [8:0]  bin,
   output logic [11:0] bcd,
   output logic        done
);
   logic [20:0] sr;
   logic [3:0]  cnt;

   // the start cycle performs the first of the nine iterations
   always_ff @(posedge clk) begin
      if (rst) begin
         sr  <= '0;
         cnt <= '0;
      end else if (start) begin
         sr  <= dd_step({12'd0, bin});
         cnt <= 4'd8;
      end else if (cnt != 4'd0) begin
         sr  <= dd_step(sr);
         cnt <= cnt - 4'd1;
      end
   end

   assign bcd  = sr[20:9];
   assign done = (cnt == 4'd1) && !start;
endmodule

// File: rtl/temp_display_scanner.sv
// temp_display_scanner: scales raw samples to temperature, converts to BCD and
// time-multiplexes three digits onto a shared active-low 7-segment bus
module temp_display_scanner
   import temp_disp_pkg::*;
#(
   parameter int unsigned SCAN_DIV = 50000
) (
   input  logic                   clk,
   input  logic                   rst,
   temp_display_scanner_if.slave  s,
   output logic [6:0]             seg,
   output logic [2:0]             an,
   output logic                   disp_update
);
   localparam logic [19:0] LAST = 20'(SCAN_DIV - 1);

   state_t      state;
   logic        ready, start, done, shown, load, sh_nx, wrap;
   logic [8:0]  temp;
   logic [11:0] bcd, digits, d_nx;
   logic [19:0] cnt;
   logic [1:0]  idx, idx_nx;
   logic [3:0]  nib;

   assign s.sample_ready = ready;

   bin2bcd_seq u_bcd (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .bin   (temp),
      .bcd   (bcd),
      .done  (done)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         ready       <= 1'b1;
         start       <= 1'b0;
         temp        <= '0;
         digits      <= '0;
         shown       <= 1'b0;
         disp_update <= 1'b0;
      end else begin
         start       <= 1'b0;
         disp_update <= 1'b0;
         case (state)
            IDLE: if (s.sample_valid) begin
               temp  <= scale_temp(s.sample_data);
               start <= 1'b1;
               ready <= 1'b0;
               state <= CONV;
            end
            CONV: if (done) state <= LOAD;
            LOAD: begin
               digits      <= bcd;
               shown       <= 1'b1;
               disp_update <= 1'b1;
               ready       <= 1'b1;
               state       <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // outputs are built from next-cycle digit/index so seg and an switch on the same edge
   always_comb begin
      load   = state == LOAD;
      d_nx   = load ? bcd : digits;
      sh_nx  = load | shown;
      wrap   = cnt == LAST;
      idx_nx = wrap ? (idx == 2'd2 ? 2'd0 : idx + 2'd1) : idx;
      nib    = idx_nx == 2'd0 ? d_nx[3:0] : idx_nx == 2'd1 ? d_nx[7:4] : d_nx[11:8];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
         idx <= '0;
         seg <= SEG_BLANK;
         an  <= 3'b110;
      end else begin
         cnt <= wrap ? '0 : cnt + 20'd1;
         idx <= idx_nx;
         seg <= sh_nx ? seg_enc(nib) : SEG_BLANK;
         an  <= ~(3'b001 << idx_nx);
      end
   end
endmodule

// File: tb/tb_temp_display_scanner.sv
// tb_temp_display_scanner: directed checks of scaling, BCD latency, scan and reset behaviour
module tb_temp_display_scanner;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [6:0] seg;
   logic [2:0] an;
   logic       disp_update;
   int         n_cmp = 0;
   int         n_bad = 0;

   logic [6:0] seg_tbl [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
   logic [2:0] an_tbl [3] = '{3'b110, 3'b101, 3'b011};
   logic [7:0] vals [4] = '{8'd37, 8'd200, 8'd255, 8'd99};
   int         temps [4] = '{127, 249, 290, 174};

   temp_display_scanner_if sif();

   temp_display_scanner #(.SCAN_DIV(4)) dut (
      .clk         (clk),
      .rst         (rst),
      .s           (sif),
      .seg         (seg),
      .an          (an),
      .disp_update (disp_update)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
      n_cmp++;
      assert (obs === want) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
      end
   endtask

   function automatic logic [6:0] exp_seg(input int v, input logic [2:0] a);
      int dgt;
      dgt = (a == 3'b110) ? v % 10 : (a == 3'b101) ? (v / 10) % 10 : (a == 3'b011) ? v / 100 : -1;
      return (dgt < 0) ? 7'b1010101 : seg_tbl[dgt];
   endfunction

   task automatic check_digits(input int t);
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         check("digits", {25'd0, seg}, {25'd0, exp_seg(t, an)});
      end
   endtask

   task automatic run_sample(input logic [7:0] d, input int t);
      int lat, low;
      @(negedge clk);
      check("ready_idle", {31'd0, sif.sample_ready}, 1);
      sif.sample_valid = 1'b1;
      sif.sample_data  = d;
      @(negedge clk);
      sif.sample_valid = 1'b0;
      low = sif.sample_ready ? 0 : 1;
      lat = 0;
      for (int k = 1; k <= 30 && lat == 0; k++) begin
         @(negedge clk);
         if (disp_update) lat = k;
         else if (!sif.sample_ready) low++;
      end
      check("latency", lat, 10);
      check("ready_low", low, 10);
      @(negedge clk);
      check("pulse_width", {31'd0, disp_update}, 0);
      check_digits(t);
   endtask

   initial begin
      int cur, n_acc, n_upd, last, cyc;
      bit acc, seen;
      logic [2:0] prev;
      sif.sample_valid = 1'b0;
      sif.sample_data  = '0;
      repeat (3) @(negedge clk);
      check("rst_ready", {31'd0, sif.sample_ready}, 1);
      check("rst_upd", {31'd0, disp_update}, 0);
      check("rst_seg", {25'd0, seg}, 32'h7F);
      check("rst_an", {29'd0, an}, 3'b110);
      rst = 1'b0;
      for (int j = 1; j <= 12; j++) begin
         @(negedge clk);
         check("blank_seg", {25'd0, seg}, 32'h7F);
         check("scan_an", {29'd0, an}, {29'd0, an_tbl[(j / 4) % 3]});
      end

      run_sample(8'd0, 100);
      run_sample(8'd255, 290);
      run_sample(8'd128, 195);

      // back-to-back with valid held high
      cur = 195; n_acc = 0; n_upd = 0; last = 0; cyc = 0;
      sif.sample_valid = 1'b1;
      sif.sample_data  = vals[0];
      acc = sif.sample_ready;
      while (n_upd < 4 && cyc < 100) begin
         @(negedge clk);
         cyc++;
         if (disp_update) begin
            cur = temps[n_upd];
            n_upd++;
         end
         check("b2b_seg", {25'd0, seg}, {25'd0, exp_seg(cur, an)});
         if (acc) begin
            if (n_acc > 0) check("b2b_gap", cyc - last, 11);
            last = cyc;
            n_acc++;
            if (n_acc < 4) sif.sample_data = vals[n_acc];
            else sif.sample_valid = 1'b0;
         end
         acc = sif.sample_valid && sif.sample_ready;
      end
      check("b2b_updates", n_upd, 4);
      check("b2b_accepts", n_acc, 4);

      // land LOAD inside the tens slot
      prev = an;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (an == 3'b110 && prev != 3'b110) break;
         prev = an;
      end
      repeat (7) @(negedge clk);
      sif.sample_valid = 1'b1;
      sif.sample_data  = 8'd200;
      @(negedge clk);
      sif.sample_valid = 1'b0;
      seen = 1'b0;
      prev = an;
      for (int k = 1; k <= 16; k++) begin
         @(negedge clk);
         if (disp_update) begin
            seen = 1'b1;
            cur  = 249;
            check("tens_before", {29'd0, prev}, 3'b101);
            check("tens_at", {29'd0, an}, 3'b101);
            check("tens_lat", k, 10);
         end
         check("tens_seg", {25'd0, seg}, {25'd0, exp_seg(cur, an)});
         prev = an;
      end
      check("tens_seen", {31'd0, seen}, 1);

      // reset in the middle of a conversion
      @(negedge clk);
      sif.sample_valid = 1'b1;
      sif.sample_data  = 8'd77;
      @(negedge clk);
      sif.sample_valid = 1'b0;
      repeat (4) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("abort_ready", {31'd0, sif.sample_ready}, 1);
      check("abort_seg", {25'd0, seg}, 32'h7F);
      check("abort_an", {29'd0, an}, 3'b110);
      check("abort_upd", {31'd0, disp_update}, 0);
      seen = 1'b0;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         if (disp_update) seen = 1'b1;
         check("abort_blank", {25'd0, seg}, 32'h7F);
      end
      check("abort_no_upd", {31'd0, seen}, 0);

      // reset wins over a simultaneous sample
      @(negedge clk);
      rst = 1'b1;
      sif.sample_valid = 1'b1;
      sif.sample_data  = 8'd50;
      @(negedge clk);
      rst = 1'b0;
      sif.sample_valid = 1'b0;
      check("rstwin_ready", {31'd0, sif.sample_ready}, 1);
      seen = 1'b0;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         if (disp_update) seen = 1'b1;
      end
      check("rstwin_no_upd", {31'd0, seen}, 0);
      check("rstwin_blank", {25'd0, seg}, 32'h7F);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
